// File: rtl/tap_pkg.sv
// Shared TAP state encoding, default opcodes and the IR capture pattern used by
// the TAP controller and the scan-register block.
package tap_pkg;

   localparam logic [3:0] ST_TLR   = 4'd0;
   localparam logic [3:0] ST_RTI   = 4'd1;
   localparam logic [3:0] ST_SELDR = 4'd2;
   localparam logic [3:0] ST_CAPDR = 4'd3;
   localparam logic [3:0] ST_SHDR  = 4'd4;
   localparam logic [3:0] ST_EX1DR = 4'd5;
   localparam logic [3:0] ST_PSDR  = 4'd6;
   localparam logic [3:0] ST_EX2DR = 4'd7;
   localparam logic [3:0] ST_UPDDR = 4'd8;
   localparam logic [3:0] ST_SELIR = 4'd9;
   localparam logic [3:0] ST_CAPIR = 4'd10;
   localparam logic [3:0] ST_SHIR  = 4'd11;
   localparam logic [3:0] ST_EX1IR = 4'd12;
   localparam logic [3:0] ST_PSIR  = 4'd13;
   localparam logic [3:0] ST_EX2IR = 4'd14;
   localparam logic [3:0] ST_UPDIR = 4'd15;

   localparam logic [3:0] OPC_IDCODE = 4'b0001;
   localparam logic [3:0] OPC_USERDR = 4'b0010;

   // Fixed low bits loaded into the IR at Capture-IR; upper bits are zero.
   localparam logic [1:0] IR_CAPTURE = 2'b01;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USER
   } dr_sel_e;

endpackage

// File: rtl/tap_scan_regs_if.sv
// Scan-pin bundle between the TAP controller side and the scan-register block.
interface tap_scan_regs_if;

   logic TDI;
   logic state_obs0;
   logic state_obs1;
   logic state_obs2;
   logic state_obs3;
   logic TDO;
   logic TDO_en;

   modport master (
      output TDI, state_obs0, state_obs1, state_obs2, state_obs3,
      input  TDO, TDO_en
   );

   modport slave (
      input  TDI, state_obs0, state_obs1, state_obs2, state_obs3,
      output TDO, TDO_en
   );

endinterface

// File: rtl/tap_shift_reg.sv
// Capture/shift register for one scan chain: parallel load on capture, shift
// right with serial input entering the MSB; the LSB is the serial output.
module tap_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic             shift,
   input  logic [WIDTH-1:0] pdata,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (capture) begin
         q <= pdata;
      end else if (shift) begin
         q <= {sin, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/tap_scan_regs.sv
// JTAG instruction and data registers (BYPASS, IDCODE, user DR) driven by the
// TAP controller's state code, with the TDI-to-TDO serial path.
module tap_scan_regs
   import tap_pkg::*;
#(
   parameter int                   IR_WIDTH      = 4,
   parameter logic [31:0]          IDCODE_VAL    = 32'h0BA0_0477,
   parameter int                   USER_DR_WIDTH = 8,
   parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE  = IR_WIDTH'(OPC_IDCODE),
   parameter logic [IR_WIDTH-1:0]  INSTR_USERDR  = IR_WIDTH'(OPC_USERDR)
) (
   input  logic                      TCK,
   input  logic                      TRST,
   tap_scan_regs_if.slave            scan,
   output logic [IR_WIDTH-1:0]       ir_value,
   input  logic [USER_DR_WIDTH-1:0]  user_dr_in,
   output logic [USER_DR_WIDTH-1:0]  user_dr_out,
   output logic                      user_dr_upd
);

   logic [3:0]               state;
   dr_sel_e                  sel;
   logic                     cap_dr;
   logic                     sh_dr;
   logic [IR_WIDTH-1:0]      ir_shift;
   logic [31:0]              id_q;
   logic [USER_DR_WIDTH-1:0] udr_q;
   logic                     bypass;

   assign state  = {scan.state_obs3, scan.state_obs2, scan.state_obs1, scan.state_obs0};
   assign cap_dr = (state == ST_CAPDR);
   assign sh_dr  = (state == ST_SHDR);

   // Only bit 0 of IDCODE is observed; the rest just shift toward it.
   logic unused_id;
   assign unused_id = ^id_q[31:1];

   always_comb begin
      sel = DR_BYPASS;
      if (ir_value == INSTR_IDCODE) begin
         sel = DR_IDCODE;
      end else if (ir_value == INSTR_USERDR) begin
         sel = DR_USER;
      end
   end

   tap_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
      .clk     (TCK),
      .rst     (TRST),
      .capture (state == ST_CAPIR),
      .shift   (state == ST_SHIR),
      .pdata   (IR_WIDTH'(IR_CAPTURE)),
      .sin     (scan.TDI),
      .q       (ir_shift)
   );

   tap_shift_reg #(.WIDTH(32)) u_idcode (
      .clk     (TCK),
      .rst     (TRST),
      .capture (cap_dr && (sel == DR_IDCODE)),
      .shift   (sh_dr && (sel == DR_IDCODE)),
      .pdata   (IDCODE_VAL),
      .sin     (scan.TDI),
      .q       (id_q)
   );

   tap_shift_reg #(.WIDTH(USER_DR_WIDTH)) u_user_dr (
      .clk     (TCK),
      .rst     (TRST),
      .capture (cap_dr && (sel == DR_USER)),
      .shift   (sh_dr && (sel == DR_USER)),
      .pdata   (user_dr_in),
      .sin     (scan.TDI),
      .q       (udr_q)
   );

   always_ff @(posedge TCK) begin
      if (TRST) begin
         bypass <= 1'b0;
      end else if (cap_dr && (sel == DR_BYPASS)) begin
         bypass <= 1'b0;
      end else if (sh_dr && (sel == DR_BYPASS)) begin
         bypass <= scan.TDI;
      end
   end

   // The active instruction only moves at Update-IR, Test-Logic-Reset or TRST.
   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_value <= INSTR_IDCODE;
      end else if (state == ST_TLR) begin
         ir_value <= INSTR_IDCODE;
      end else if (state == ST_UPDIR) begin
         ir_value <= ir_shift;
      end
   end

   always_ff @(posedge TCK) begin
      if (TRST) begin
         user_dr_out <= '0;
         user_dr_upd <= 1'b0;
      end else begin
         user_dr_upd <= (state == ST_UPDDR) && (sel == DR_USER);
         if ((state == ST_UPDDR) && (sel == DR_USER)) begin
            user_dr_out <= udr_q;
         end
      end
   end

   always_comb begin
      scan.TDO    = 1'b0;
      scan.TDO_en = 1'b0;
      if (state == ST_SHIR) begin
         scan.TDO    = ir_shift[0];
         scan.TDO_en = 1'b1;
      end else if (sh_dr) begin
         scan.TDO_en = 1'b1;
         case (sel)
            DR_IDCODE: scan.TDO = id_q[0];
            DR_USER:   scan.TDO = udr_q[0];
            default:   scan.TDO = bypass;
         endcase
      end
   end

endmodule
